// File: rtl/qr_grid_sampler_if.sv
// qr_grid_sampler_if: finder/pitch start inputs, pixel-buffer read port and sampled-bit stream.
interface qr_grid_sampler_if #(parameter int ADDR_W = 17);
   logic [2:0][8:0]   centers_x;
   logic [2:0][8:0]   centers_y;
   logic [8:0]        mod_size;
   logic              mod_size_valid;
   logic [ADDR_W-1:0] pixel_addr_out;
   logic              pixel_in;
   logic              bit_out;
   logic [4:0]        row_out;
   logic [4:0]        col_out;
   logic              bit_valid_out;
   logic              busy_out;
   logic              done_out;
   logic              oob_out;
   modport master (output centers_x, centers_y, mod_size, mod_size_valid, pixel_in,
                   input  pixel_addr_out, bit_out, row_out, col_out, bit_valid_out, busy_out, done_out, oob_out);
   modport slave  (input  centers_x, centers_y, mod_size, mod_size_valid, pixel_in,
                   output pixel_addr_out, bit_out, row_out, col_out, bit_valid_out, busy_out, done_out, oob_out);
endinterface

// File: rtl/qr_grid_sampler.sv
// qr_grid_sampler: walks a MODULES x MODULES grid from the top-left finder and streams one sampled bit per
// module from a 2-cycle-latency pixel buffer; SAMPLER_MAJORITY_EN takes a 3-pixel horizontal majority instead.
module qr_grid_sampler #(
   parameter int MODULES = 21,
   parameter int IMG_W   = 320,
   parameter int IMG_H   = 240,
   parameter int ADDR_W  = 17
) (
   input logic              clk_in,
   input logic              rst_n_in,
   qr_grid_sampler_if.slave bus
);
   typedef enum logic [2:0] {IDLE, SETUP, ISSUE, DRAIN, DONE} state_t;
   typedef struct packed {
      logic       v;
      logic       oob;
      logic       last;
      logic [4:0] row;
      logic [4:0] col;
   } meta_t;
`ifdef SAMPLER_MAJORITY_EN
   localparam logic [1:0] L_LAST = 2'd2;
`else
   localparam logic [1:0] L_LAST = 2'd0;
`endif
   localparam logic signed [15:0] L_W = 16'(IMG_W);
   localparam logic signed [15:0] L_H = 16'(IMG_H);
   localparam logic [4:0] L_END = 5'(MODULES - 1);
   state_t             r_state, w_next;
   logic [8:0]         r_ms, r_cx, r_cy;
   logic signed [15:0] r_ox, r_x, r_y, w_ox, w_oy, w_step, w_px;
   logic [10:0]        w_m3;
   logic [4:0]         r_row, r_col, r_brow, r_bcol;
   logic [1:0]         r_sub;
   logic [ADDR_W-1:0]  r_addr, w_lin;
   meta_t [2:0]        r_p;
   meta_t              w_meta;
   logic               r_bit, r_bv, r_oob;
   logic               w_oob, w_last_mod, w_row_end, w_last, w_s, w_bit, w_unused;
   // (7m>>1) - (m>>1) equals 3m for every m, so the origin offset is one shift-add
   assign w_m3   = {1'b0, r_ms, 1'b0} + {2'b0, r_ms};
   assign w_ox   = $signed({7'b0, r_cx}) - $signed({5'b0, w_m3});
   assign w_oy   = $signed({7'b0, r_cy}) - $signed({5'b0, w_m3});
   assign w_step = $signed({7'b0, r_ms});
   assign w_s    = !r_p[2].oob && bus.pixel_in;
`ifdef SAMPLER_MAJORITY_EN
   logic [1:0] r_acc;
   always_ff @(posedge clk_in or negedge rst_n_in)
      if (!rst_n_in)      r_acc <= '0;
      else if (r_p[2].v) r_acc <= {r_acc[0], w_s};
   assign w_px  = r_x + $signed({14'b0, r_sub}) - 16'sd1;
   assign w_bit = (r_acc[1] & r_acc[0]) | (w_s & (r_acc[1] | r_acc[0]));
`else
   assign w_px  = r_x;
   assign w_bit = w_s;
`endif
   assign w_oob      = (w_px < 16'sd0) || (w_px >= L_W) || (r_y < 16'sd0) || (r_y >= L_H);
   assign w_lin      = ADDR_W'(32'(r_y) * IMG_W + 32'(w_px));
   assign w_last_mod = r_sub == L_LAST;
   assign w_row_end  = r_col == L_END;
   assign w_last     = w_last_mod && w_row_end && (r_row == L_END);
   assign w_meta     = meta_t'{v: r_state == ISSUE, oob: w_oob, last: w_last_mod, row: r_row, col: r_col};
   assign w_unused   = ^{bus.centers_x[0], bus.centers_x[2], bus.centers_y[0], bus.centers_y[2]};
   always_ff @(posedge clk_in or negedge rst_n_in)
      if (!rst_n_in) r_state <= IDLE;
      else           r_state <= w_next;
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (bus.mod_size_valid) w_next = SETUP;
         SETUP:   if (r_ms == '0) w_next = DONE; else w_next = ISSUE;
         ISSUE:   if (w_last) w_next = DRAIN;
         DRAIN:   if (r_bv && !(r_p[0].v || r_p[1].v || r_p[2].v)) w_next = DONE;
         default: w_next = IDLE;
      endcase
   end
   always_comb begin
      bus.busy_out = r_state != IDLE;
      bus.done_out = r_state == DONE;
   end
   assign bus.pixel_addr_out = r_addr;
   assign bus.bit_out        = r_bit;
   assign bus.bit_valid_out  = r_bv;
   assign bus.row_out        = r_brow;
   assign bus.col_out        = r_bcol;
   assign bus.oob_out        = r_oob;
   always_ff @(posedge clk_in or negedge rst_n_in)
      if (!rst_n_in) begin
         r_ms   <= '0;
         r_cx   <= '0;
         r_cy   <= '0;
         r_ox   <= '0;
         r_x    <= '0;
         r_y    <= '0;
         r_row  <= '0;
         r_col  <= '0;
         r_sub  <= '0;
         r_addr <= '0;
         r_p    <= '0;
         r_bit  <= 1'b0;
         r_bv   <= 1'b0;
         r_brow <= '0;
         r_bcol <= '0;
         r_oob  <= 1'b0;
      end else begin
         if (r_state == IDLE && bus.mod_size_valid) begin
            r_ms <= bus.mod_size;
            r_cx <= bus.centers_x[1];
            r_cy <= bus.centers_y[1];
         end
         if (r_state == SETUP) begin
            r_ox  <= w_ox;
            r_x   <= w_ox;
            r_y   <= w_oy;
            r_row <= '0;
            r_col <= '0;
            r_sub <= '0;
            r_oob <= r_ms == '0;
         end
         if (r_state == ISSUE) begin
            r_sub <= w_last_mod ? '0 : r_sub + 2'd1;
            if (w_last_mod) begin
               r_col <= w_row_end ? '0 : r_col + 5'd1;
               r_row <= w_row_end ? r_row + 5'd1 : r_row;
               r_x   <= w_row_end ? r_ox : r_x + w_step;
               r_y   <= w_row_end ? r_y + w_step : r_y;
            end
            if (w_oob) r_oob <= 1'b1;
         end
         r_addr <= (r_state == ISSUE && !w_oob) ? w_lin : '0;
         r_p    <= {r_p[1:0], w_meta};
         r_bv   <= r_p[2].v && r_p[2].last;
         r_bit  <= r_p[2].v && r_p[2].last && w_bit;
         r_brow <= r_p[2].row;
         r_bcol <= r_p[2].col;
      end
endmodule

// File: tb/tb_qr_grid_sampler.sv
// tb_qr_grid_sampler: directed and random-image scans of qr_grid_sampler checked against an arithmetic
// grid model; follows SAMPLER_MAJORITY_EN when defined.
module tb_qr_grid_sampler;
   localparam int M = 21, W = 320, H = 240, AW = 17;
`ifdef SAMPLER_MAJORITY_EN
   localparam int NS = 3;
`else
   localparam int NS = 1;
`endif
   typedef struct packed { int row; int col; int b; int a0; int a1; int a2; int cyc; } obs_t;
   logic clk = 1'b0, rst_n = 1'b0;
   bit img [W*H];
   logic [AW-1:0] pd1 = '0, pd2 = '0;
   obs_t obs[$];
   int ahist[$];
   int cyc = 0, done_cnt = 0, done_cyc = 0, d0 = 0, tests = 0, fails = 0;
   logic done_oob = 1'b0;
   always #5 clk = ~clk;
   qr_grid_sampler_if #(.ADDR_W(AW)) bus ();
   qr_grid_sampler #(.MODULES(M), .IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
      .clk_in(clk), .rst_n_in(rst_n), .bus(bus));
   // pixel buffer: data for an address appears two cycles after it
   always @(posedge clk) begin
      pd1 <= bus.pixel_addr_out;
      pd2 <= pd1;
   end
   assign bus.pixel_in = img[pd2];
   function automatic int hist(input int back);
      return (ahist.size() >= back) ? ahist[ahist.size() - back] : -1;
   endfunction
   function automatic int obs_addr(input obs_t o, input int k);
      return (k == 0) ? o.a0 : (k == 1) ? o.a1 : o.a2;
   endfunction
   function automatic int center(input obs_t o);
      return (NS == 3) ? o.a1 : o.a2;
   endfunction
   always @(posedge clk) begin
      #1;
      cyc++;
      ahist.push_back(int'(bus.pixel_addr_out));
      if (bus.bit_valid_out)
         obs.push_back(obs_t'{row: int'(bus.row_out), col: int'(bus.col_out), b: int'(bus.bit_out),
                              a0: hist(6), a1: hist(5), a2: hist(4), cyc: cyc});
      if (bus.done_out) begin
         done_cnt++;
         done_cyc = cyc;
         done_oob = bus.oob_out;
      end
   end
   task automatic chk(input string tag, input longint got, input longint exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask
   task automatic start(input int cx, input int cy, input int ms);
      @(negedge clk);
      obs.delete();
      ahist.delete();
      d0 = done_cnt;
      bus.centers_x = {9'($urandom), 9'(cx), 9'($urandom)};
      bus.centers_y = {9'($urandom), 9'(cy), 9'($urandom)};
      bus.mod_size = 9'(ms);
      bus.mod_size_valid = 1'b1;
      @(negedge clk);
      bus.mod_size_valid = 1'b0;
      chk("busy after start", int'(bus.busy_out), 1);
   endtask
   task automatic wait_done(input string tag);
      int i = 0;
      while (done_cnt == d0 && i < 4000) begin
         @(negedge clk);
         i++;
      end
      chk({tag, " done count"}, done_cnt, d0 + 1);
      repeat (4) @(negedge clk);
      chk({tag, " busy after done"}, int'(bus.busy_out), 0);
   endtask
   // grid model: point (r,c) sits at origin + (c,r)*pitch, origin from the finder-centre rule
   task automatic verify(input string tag, input int cx, input int cy, input int ms, input bit full);
      int ox, oy, n, eoob;
      ox = cx - ((7 * ms) >> 1) + (ms >> 1);
      oy = cy - ((7 * ms) >> 1) + (ms >> 1);
      eoob = 0;
      n = obs.size();
      if (full) chk({tag, " bit count"}, n, M * M);
      for (int i = 0; i < n && i < M * M; i++) begin
         int r, c, x, y, sum, px, ea;
         r = i / M;
         c = i % M;
         x = ox + c * ms;
         y = oy + r * ms;
         sum = 0;
         chk({tag, " row"}, obs[i].row, r);
         chk({tag, " col"}, obs[i].col, c);
         for (int s = 0; s < NS; s++) begin
            px = x + ((NS == 3) ? s - 1 : 0);
            if (px >= 0 && px < W && y >= 0 && y < H) begin
               ea = y * W + px;
               sum += int'(img[ea]);
            end else begin
               ea = 0;
               eoob = 1;
            end
            chk({tag, " addr"}, obs_addr(obs[i], 3 - NS + s), ea);
         end
         chk({tag, " bit"}, obs[i].b, (2 * sum > NS) ? 1 : 0);
      end
      if (full) begin
         chk({tag, " oob"}, int'(done_oob), eoob);
         chk({tag, " done latency"}, (n > 0) ? done_cyc - obs[n-1].cyc : -1, 1);
      end
   endtask
   initial begin
      int cx, cy, ms, i;
      bus.centers_x = '0;
      bus.centers_y = '0;
      bus.mod_size = '0;
      bus.mod_size_valid = 1'b0;
      foreach (img[k]) img[k] = 1'($urandom_range(0, 1));
      repeat (3) @(negedge clk);
      chk("reset outputs", longint'({bus.pixel_addr_out, bus.bit_out, bus.row_out, bus.col_out,
                                     bus.bit_valid_out, bus.busy_out, bus.done_out, bus.oob_out}), 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      // majority patterns 1,0,1 and 0,0,1 around the first two module centres
      img[18*W+27] = 1'b1; img[18*W+28] = 1'b0; img[18*W+29] = 1'b1;
      img[18*W+31] = 1'b0; img[18*W+32] = 1'b0; img[18*W+33] = 1'b1;
      start(40, 30, 4);
      wait_done("A");
      verify("A", 40, 30, 4, 1);
      chk("A first addr", (obs.size() > 0) ? center(obs[0]) : -1, 5788);
      chk("A last addr", (obs.size() > 0) ? center(obs[obs.size()-1]) : -1, 31468);
      chk("A oob", int'(done_oob), 0);
`ifdef SAMPLER_MAJORITY_EN
      chk("A maj 101", (obs.size() > 1) ? obs[0].b : -1, 1);
      chk("A maj 001", (obs.size() > 1) ? obs[1].b : -1, 0);
`endif
      start(5, 30, 4);
      wait_done("B");
      verify("B", 5, 30, 4, 1);
      chk("B col0 addr", (obs.size() > 2) ? center(obs[0]) : -1, 0);
      chk("B col1 bit", (obs.size() > 2) ? obs[1].b : -1, 0);
      chk("B col2 addr", (obs.size() > 2) ? center(obs[2]) : -1, 18 * W + 1);
      chk("B oob", int'(done_oob), 1);
      start(50, 50, 0);
      wait_done("C");
      chk("C bits", obs.size(), 0);
      chk("C oob", int'(done_oob), 1);
      for (int k = 0; k < 3; k++) begin
         cx = $urandom_range(0, 400);
         cy = $urandom_range(0, 300);
         ms = $urandom_range(1, 15);
         start(cx, cy, ms);
         wait_done("rand");
         verify("rand", cx, cy, ms, 1);
      end
      start(40, 30, 4);
      repeat (20) @(negedge clk);
      bus.centers_x[1] = 9'd200;
      bus.mod_size = 9'd7;
      bus.mod_size_valid = 1'b1;
      @(negedge clk);
      bus.mod_size_valid = 1'b0;
      i = 0;
      while (obs.size() < 100 && i < 2000) begin
         @(negedge clk);
         i++;
      end
      chk("R reached module 100", obs.size() >= 100, 1);
      #2 rst_n = 1'b0;
      #1 chk("R outputs in reset", longint'({bus.pixel_addr_out, bus.bit_out, bus.row_out, bus.col_out,
                                              bus.bit_valid_out, bus.busy_out, bus.done_out, bus.oob_out}), 0);
      verify("R prefix", 40, 30, 4, 0);
      obs.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      chk("R no residual bits", obs.size(), 0);
      chk("R no done", done_cnt, d0);
      start(60, 50, 5);
      wait_done("R2");
      verify("R2", 60, 50, 5, 1);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
